// File: rtl/trees_pkg.sv
// trees_pkg
// Shared definitions for the tree-accelerator burst controller.
//   state_t            : controller FSM states
//   WORDS_PER_SAMPLE   : 64-bit feature words per sample (two 32-bit features
//                        per word) for the default 32-feature configuration
//   words_per_sample() : the same quantity for any feature count
//   mask_tail()        : zeroes the unused prediction bytes of a final word
package trees_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_READ
    } state_t;

    localparam int DEFAULT_N_FEATURE = 32;
    localparam int WORDS_PER_SAMPLE  = DEFAULT_N_FEATURE / 2;

    function automatic int words_per_sample(input int n_feature);
        return n_feature / 2;
    endfunction

    // keep == 0 means every byte of the word carries a valid prediction.
    function automatic logic [63:0] mask_tail(input logic [63:0] word,
                                              input logic [2:0]  keep);
        logic [63:0] result;
        result = word;
        if (keep != 3'd0) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= int'(keep)) begin
                    result[i*8 +: 8] = 8'h00;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/trees_out_reg.sv
// trees_out_reg
// One-word output register with valid/ready hold. A word offered on the load
// side is captured when the register is empty or is being drained in the same
// cycle, so a continuously ready consumer sees one word per cycle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   load_valid/load_ready           offer of the next word from the producer
//   load_data, load_last            word and end-of-stream marker
//   out_valid/out_ready             downstream handshake
//   out_data, out_last              held word and end-of-stream marker
module trees_out_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    assign load_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load_valid && load_ready) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_ready) begin
            // Data is left in place; only the qualifiers drop once consumed.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/trees_burst_ctrl.sv
// trees_burst_ctrl
// Runs one inference burst on the tree accelerator: accepts a burst length,
// streams the feature words into the accelerator's feature memory, pulses
// acc_start, waits for acc_done (with a timeout), then streams the packed
// byte-wide predictions out.
// Ports:
//   clk, rst_n                               clock, asynchronous active-low reset
//   cfg_valid/cfg_ready, cfg_burst_len       burst request
//   in_valid/in_ready, in_data               feature word stream (sample-major)
//   acc_load_features, acc_feature_addr,
//   acc_features                             feature-memory write port
//   acc_burst_len, acc_start, acc_done       accelerator run control
//   acc_prediction_addr, acc_prediction      prediction read port (combinational)
//   out_valid/out_ready, out_data, out_last  prediction word stream
//   busy, error                              not idle / sticky fault
module trees_burst_ctrl
    import trees_pkg::*;
#(
    parameter int N_FEATURE      = 32,
    parameter int MAX_BURST      = 5000,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [$clog2(MAX_BURST)-1:0]           cfg_burst_len,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [63:0]                            in_data,
    output logic                                   acc_load_features,
    output logic [$clog2(MAX_BURST*N_FEATURE)-1:0] acc_feature_addr,
    output logic [63:0]                            acc_features,
    output logic [$clog2(MAX_BURST)-1:0]           acc_burst_len,
    output logic                                   acc_start,
    input  logic                                   acc_done,
    output logic [$clog2(MAX_BURST)-1:0]           acc_prediction_addr,
    input  logic [63:0]                            acc_prediction,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [63:0]                            out_data,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   error
);

    localparam int LEN_W   = $clog2(MAX_BURST);
    localparam int FADDR_W = $clog2(MAX_BURST*N_FEATURE);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WPS     = words_per_sample(N_FEATURE);

    state_t             state;
    logic [LEN_W-1:0]   burst_len_q;
    logic [FADDR_W-1:0] word_cnt;
    logic [TO_W-1:0]    wait_cnt;
    logic [LEN_W-1:0]   rd_cnt;

    logic               cfg_ok;
    logic               load_fire;
    logic [FADDR_W-1:0] last_word_addr;
    logic [LEN_W-1:0]   n_pred_words;
    logic               fetch_valid;
    logic               fetch_ready;
    logic               fetch_last;
    logic [63:0]        fetch_data;
    logic               out_fire;

    assign cfg_ok = (int'(cfg_burst_len) != 0) && (int'(cfg_burst_len) <= MAX_BURST);

    // Feature words are written straight through in the handshake cycle.
    assign cfg_ready         = (state == ST_IDLE);
    assign in_ready          = (state == ST_LOAD);
    assign load_fire         = in_valid && in_ready;
    assign acc_load_features = load_fire;
    assign acc_features      = in_data;
    assign acc_feature_addr  = word_cnt;
    assign acc_burst_len     = burst_len_q;
    assign acc_start         = (state == ST_START);
    assign busy              = (state != ST_IDLE);

    assign last_word_addr = FADDR_W'(burst_len_q) * FADDR_W'(WPS) - FADDR_W'(1);

    // Eight predictions per word, rounded up.
    assign n_pred_words = (burst_len_q >> 3) + LEN_W'(burst_len_q[2:0] != 3'd0);

    // The prediction port is combinational, so the read address doubles as the
    // fetch pointer; it only advances when the output register takes the word.
    assign acc_prediction_addr = rd_cnt;
    assign fetch_valid = (state == ST_READ) && (rd_cnt != n_pred_words);
    assign fetch_last  = (rd_cnt == n_pred_words - LEN_W'(1));
    assign fetch_data  = fetch_last ? mask_tail(acc_prediction, burst_len_q[2:0])
                                    : acc_prediction;
    assign out_fire    = out_valid && out_ready;

    trees_out_reg #(
        .W (64)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (fetch_valid),
        .load_ready (fetch_ready),
        .load_data  (fetch_data),
        .load_last  (fetch_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    // Burst sequencing. acc_done is only looked at in WAIT, so stray pulses
    // elsewhere have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            burst_len_q <= '0;
            word_cnt    <= '0;
            wait_cnt    <= '0;
            rd_cnt      <= '0;
            error       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_ok) begin
                            burst_len_q <= cfg_burst_len;
                            error       <= 1'b0;
                            word_cnt    <= '0;
                            state       <= ST_LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        if (word_cnt == last_word_addr) begin
                            word_cnt <= '0;
                            state    <= ST_START;
                        end else begin
                            word_cnt <= word_cnt + FADDR_W'(1);
                        end
                    end
                end
                ST_START: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (acc_done) begin
                        wait_cnt <= '0;
                        rd_cnt   <= '0;
                        state    <= ST_READ;
                    end else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        wait_cnt <= '0;
                        error    <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ST_READ: begin
                    if (fetch_valid && fetch_ready) begin
                        rd_cnt <= rd_cnt + LEN_W'(1);
                    end
                    if (out_fire && out_last) begin
                        rd_cnt <= '0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trees_burst_ctrl.sv
// tb_trees_burst_ctrl
// Directed bench for trees_burst_ctrl with a behavioural accelerator: the
// prediction port returns byte {1, idx[6:0]} for prediction index idx, and
// acc_done answers acc_start after a few cycles unless disabled.
module tb_trees_burst_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [12:0] cfg_burst_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        acc_load_features;
    logic [17:0] acc_feature_addr;
    logic [63:0] acc_features;
    logic [12:0] acc_burst_len;
    logic        acc_start;
    logic        acc_done;
    logic [12:0] acc_prediction_addr;
    logic [63:0] acc_prediction;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        error;

    logic        resp_done;
    logic        stray_done;
    logic        done_en;

    int          tests_run;
    int          tests_failed;
    int          cyc;
    int          start_cnt;
    int          wr_cnt;
    int          wr_err;
    logic [17:0] exp_addr;

    logic [63:0] got_data [8];
    logic        got_last [8];
    int          got_cyc  [8];
    int          n_got;
    int          stall_err;

    int          snap_wr;
    int          snap_err;
    int          snap_start;
    int          wait_cycles;
    logic        seen;

    trees_burst_ctrl #(
        .N_FEATURE      (32),
        .MAX_BURST      (5000),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_burst_len       (cfg_burst_len),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .acc_load_features   (acc_load_features),
        .acc_feature_addr    (acc_feature_addr),
        .acc_features        (acc_features),
        .acc_burst_len       (acc_burst_len),
        .acc_start           (acc_start),
        .acc_done            (acc_done),
        .acc_prediction_addr (acc_prediction_addr),
        .acc_prediction      (acc_prediction),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .busy                (busy),
        .error               (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] feat_word(input int i);
        return {32'(2*i + 1), 32'(2*i)};
    endfunction

    function automatic logic [63:0] pred_word(input logic [12:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*8 +: 8] = {1'b1, 7'(int'(a)*8 + k)};
        end
        return r;
    endfunction

    assign acc_prediction = pred_word(acc_prediction_addr);
    assign acc_done       = resp_done | stray_done;

    // Accelerator model: answer each acc_start with a one-cycle acc_done.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_start && done_en) begin
                repeat (5) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    // Feature-write monitor: every write must hit the next address in order
    // with the word the bench sent for that address.
    always @(negedge clk) begin
        if (acc_start) start_cnt <= start_cnt + 1;
        if (acc_load_features) begin
            wr_cnt <= wr_cnt + 1;
            if (acc_feature_addr !== exp_addr || acc_features !== feat_word(int'(exp_addr)))
                wr_err <= wr_err + 1;
            exp_addr <= exp_addr + 18'd1;
        end else if (!busy) begin
            exp_addr <= '0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic doConfig(input int len);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cfg_valid     = 1'b1;
        cfg_burst_len = 13'(len);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (!ok) checkOutput("cfg_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic feedWords(input int n);
        logic ok;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = feat_word(i);
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            if (!ok) begin
                checkOutput("in_handshake_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input int n_words);
        doConfig(len);
        feedWords(n_words);
    endtask

    // Drains the prediction stream; toggle alternates out_ready every cycle
    // and checks that a stalled word does not change.
    task automatic collectOut(input logic toggle);
        logic        done;
        logic        prev_stall;
        logic [63:0] prev_data;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        n_got      = 0;
        stall_err  = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            out_ready = toggle ? ~out_ready : 1'b1;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                if (n_got < 8) begin
                    got_data[n_got] = out_data;
                    got_last[n_got] = out_last;
                    got_cyc[n_got]  = cyc;
                end
                n_got++;
                if (out_last) done = 1'b1;
            end
        end
        if (!done) checkOutput("out_last_timeout", 64'd0, 64'd1);
    endtask

    task automatic takeSnapshot();
        snap_wr    = wr_cnt;
        snap_err   = wr_err;
        snap_start = start_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        cyc           = 0;
        start_cnt     = 0;
        wr_cnt        = 0;
        wr_err        = 0;
        exp_addr      = '0;
        rst_n         = 1'b0;
        cfg_valid     = 1'b0;
        cfg_burst_len = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b1;
        stray_done    = 1'b0;
        done_en       = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",      64'(busy),              64'd0);
        checkOutput("rst_error",     64'(error),             64'd0);
        checkOutput("rst_out_valid", 64'(out_valid),         64'd0);
        checkOutput("rst_out_last",  64'(out_last),          64'd0);
        checkOutput("rst_acc_start", 64'(acc_start),         64'd0);
        checkOutput("rst_acc_load",  64'(acc_load_features), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_cfg_ready", 64'(cfg_ready),         64'd1);

        // burst_len = 1: 16 feature words, one masked prediction word
        takeSnapshot();
        applyStimulus(1, 16);
        checkOutput("b1_acc_burst_len", 64'(acc_burst_len), 64'd1);
        collectOut(1'b0);
        @(negedge clk);
        checkOutput("b1_writes",    64'(wr_cnt - snap_wr),        64'd16);
        checkOutput("b1_write_err", 64'(wr_err - snap_err),       64'd0);
        checkOutput("b1_starts",    64'(start_cnt - snap_start),  64'd1);
        checkOutput("b1_n_out",     64'(n_got),                   64'd1);
        checkOutput("b1_word0",     got_data[0],                  64'h0000_0000_0000_0080);
        checkOutput("b1_last0",     64'(got_last[0]),             64'd1);
        checkOutput("b1_idle",      64'(busy),                    64'd0);
        checkOutput("b1_error",     64'(error),                   64'd0);

        // burst_len = 9 with a stray acc_done during LOAD
        takeSnapshot();
        doConfig(9);
        @(posedge clk); #1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        checkOutput("b9_stray_ignored_busy", 64'(busy), 64'd1);
        feedWords(144);
        collectOut(1'b0);
        @(negedge clk);
        checkOutput("b9_writes",    64'(wr_cnt - snap_wr),       64'd144);
        checkOutput("b9_write_err", 64'(wr_err - snap_err),      64'd0);
        checkOutput("b9_starts",    64'(start_cnt - snap_start), 64'd1);
        checkOutput("b9_n_out",     64'(n_got),                  64'd2);
        checkOutput("b9_word0",     got_data[0],                 64'h8786_8584_8382_8180);
        checkOutput("b9_last0",     64'(got_last[0]),            64'd0);
        checkOutput("b9_word1",     got_data[1],                 64'h0000_0000_0000_0088);
        checkOutput("b9_last1",     64'(got_last[1]),            64'd1);
        checkOutput("b9_back2back", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
        checkOutput("b9_idle",      64'(busy),                   64'd0);

        // burst_len = 20 with out_ready toggling every cycle
        takeSnapshot();
        out_ready = 1'b0;
        applyStimulus(20, 320);
        collectOut(1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("b20_writes", 64'(wr_cnt - snap_wr), 64'd320);
        checkOutput("b20_n_out",  64'(n_got),            64'd3);
        checkOutput("b20_stall",  64'(stall_err),        64'd0);
        checkOutput("b20_word0",  got_data[0],           64'h8786_8584_8382_8180);
        checkOutput("b20_word1",  got_data[1],           64'h8F8E_8D8C_8B8A_8988);
        checkOutput("b20_word2",  got_data[2],           64'h0000_0000_9392_9190);
        checkOutput("b20_last2",  64'(got_last[2]),      64'd1);

        // Illegal burst lengths
        foreach (got_cyc[i]) got_cyc[i] = 0;
        takeSnapshot();
        doConfig(0);
        @(negedge clk);
        checkOutput("len0_error",     64'(error),     64'd1);
        checkOutput("len0_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("len0_busy",      64'(busy),      64'd0);
        doConfig(5001);
        repeat (3) @(negedge clk);
        checkOutput("len5001_error",     64'(error),                  64'd1);
        checkOutput("len5001_cfg_ready", 64'(cfg_ready),              64'd1);
        checkOutput("bad_len_starts",    64'(start_cnt - snap_start), 64'd0);

        // Timeout: acc_done never comes back
        done_en = 1'b0;
        takeSnapshot();
        applyStimulus(1, 16);
        checkOutput("to_error_cleared", 64'(error), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (acc_start) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("to_start_seen", 64'(seen), 64'd1);
        wait_cycles = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (error) break;
            wait_cycles++;
        end
        checkOutput("to_wait_cycles", 64'(wait_cycles), 64'd100);
        checkOutput("to_error",       64'(error),       64'd1);
        checkOutput("to_idle",        64'(busy),        64'd0);
        checkOutput("to_cfg_ready",   64'(cfg_ready),   64'd1);
        done_en = 1'b1;

        // Reset in the middle of LOAD, then a clean burst_len = 2
        takeSnapshot();
        applyStimulus(2, 10);
        in_valid = 1'b1;
        in_data  = feat_word(10);
        rst_n    = 1'b0;
        #1;
        checkOutput("mid_rst_busy",     64'(busy),              64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready),          64'd0);
        checkOutput("mid_rst_acc_load", 64'(acc_load_features), 64'd0);
        checkOutput("mid_rst_cfg_rdy",  64'(cfg_ready),         64'd1);
        checkOutput("mid_rst_error",    64'(error),             64'd0);
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_writes", 64'(wr_cnt - snap_wr),       64'd10);
        checkOutput("mid_rst_starts", 64'(start_cnt - snap_start), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        takeSnapshot();
        applyStimulus(2, 32);
        collectOut(1'b0);
        @(negedge clk);
        checkOutput("b2_writes",    64'(wr_cnt - snap_wr),       64'd32);
        checkOutput("b2_write_err", 64'(wr_err - snap_err),      64'd0);
        checkOutput("b2_starts",    64'(start_cnt - snap_start), 64'd1);
        checkOutput("b2_n_out",     64'(n_got),                  64'd1);
        checkOutput("b2_word0",     got_data[0],                 64'h0000_0000_0000_8180);
        checkOutput("b2_idle",      64'(busy),                   64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/trees_burst_ctrl.md
TREES_BURST_CTRL -- requirements
Module: trees_burst_ctrl

Interface
REQ-001 SHALL have parameter N_FEATURE, default 32, meaning 32-bit features per sample, two packed per 64-bit word.
REQ-002 SHALL have parameter MAX_BURST, default 5000, meaning maximum samples per burst.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2**20, meaning maximum cycles to wait for acc_done.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to clk.
REQ-005 SHALL have port: clk  in  1  clock.
REQ-006 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: cfg_valid in 1, cfg_ready out 1, cfg_burst_len in $clog2(MAX_BURST), meaning burst request handshake and sample count.
REQ-008 SHALL have ports: in_valid in 1, in_ready out 1, in_data in 64, meaning feature word stream, sample-major, low feature in bits [31:0].
REQ-009 SHALL have ports: acc_load_features out 1, acc_feature_addr out $clog2(MAX_BURST*N_FEATURE), acc_features out 64, meaning feature-memory write port.
REQ-010 SHALL have ports: acc_burst_len out $clog2(MAX_BURST), acc_start out 1, acc_done in 1, meaning accelerator run control; acc_done is a one-cycle pulse.
REQ-011 SHALL have ports: acc_prediction_addr out $clog2(MAX_BURST), acc_prediction in 64, meaning prediction read port, combinational in the accelerator, 8 byte-wide predictions per word.
REQ-012 SHALL have ports: out_valid out 1, out_ready in 1, out_data out 64, out_last out 1, meaning prediction word stream.
REQ-013 SHALL have ports: busy out 1, error out 1, meaning the FSM is not in IDLE, and a sticky fault flag.

Function
REQ-014 SHALL implement the FSM IDLE -> LOAD -> START -> WAIT -> READ -> IDLE.
REQ-015 SHALL drive cfg_ready=1 only in IDLE; on a cfg handshake it SHALL register burst_len, drive it on acc_burst_len until return to IDLE, clear error, and enter LOAD.
REQ-016 SHALL, on a cfg handshake with burst_len 0 or burst_len > MAX_BURST, set error and remain in IDLE with no acc_start.
REQ-017 LOAD: in_ready=1; each in handshake SHALL produce, in the same cycle, acc_load_features=1, acc_features=in_data, and acc_feature_addr=word counter (0..burst_len*N_FEATURE/2-1).
REQ-018 LOAD SHALL exit to START in the cycle after the handshake of word burst_len*N_FEATURE/2-1; no in handshake SHALL occur outside LOAD.
REQ-019 START SHALL assert acc_start for exactly one cycle, then enter WAIT.
REQ-020 WAIT SHALL count cycles; acc_done SHALL move the FSM to READ; reaching TIMEOUT_CYCLES without acc_done SHALL set error and return to IDLE.
REQ-021 READ SHALL fetch words 0..ceil(burst_len/8)-1 by driving acc_prediction_addr and capturing acc_prediction into a one-word output register; out_valid SHALL hold with stable data until out_ready.
REQ-022 With out_ready held 1, READ SHALL sustain one word per cycle after a single fill cycle.
REQ-023 On the final word, out_last=1, and bytes at index >= burst_len mod 8 (when nonzero) SHALL be zeroed.
REQ-024 The FSM SHALL return to IDLE in the cycle after the out_last handshake.
REQ-025 acc_done received outside WAIT SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, all counters to 0, and error, busy, out_valid, out_last, acc_start, and acc_load_features to 0; cfg_ready=1 after reset release.
REQ-027 Reset asserted mid-burst SHALL abort immediately, with no further acc_* strobes.

Structure
REQ-028 The FSM state typedef and a helper constant WORDS_PER_SAMPLE = N_FEATURE/2 SHALL reside in the shared package trees_pkg.
REQ-029 The output register with valid/ready hold SHALL be the sub-module trees_out_reg; all other logic SHALL be flat.

Verification
REQ-030 burst_len=1, 16 words in -> addr 0..15 written, one acc_start, one out word with bytes[7:1]=0, out_last=1.
REQ-031 burst_len=9 -> 144 writes, out words 0 and 1, word 1 keeps byte 0 only, out_last on word 1.
REQ-032 out_ready toggled 1/0 each cycle during READ -> no word dropped or duplicated; out_data stable while stalled.
REQ-033 burst_len=0 and burst_len=5001 -> error=1, no acc_start, cfg_ready stays 1.
REQ-034 acc_done never returned, TIMEOUT_CYCLES=100 -> error=1 at cycle 100 of WAIT, FSM in IDLE.
REQ-035 rst_n pulsed low midway through LOAD -> all outputs at reset values; a subsequent burst_len=2 completes normally.
